pc_int_ctrl: RTL and testbench
==============================

Name: pc_int_ctrl

Overview:
- Parametrised successor to the plain program counter.
- Holds PC and produces NPC, as before.
- Adds synchronised interrupt capture, vectoring to a fixed ISR address, and a hardware return-address stack of configurable depth, so interrupts can nest.
- Sits between the branch mux and instruction memory. It replaces the PC register and the PC incrementer, and takes the board INT pin directly.

Parameters:
AW, 32, PC/address width in bits
PC_STEP, 1, sequential increment (word-addressed instruction memory)
RESET_PC, 0, PC value after reset
INT_VEC, 'h40, ISR entry address
STACK_DEPTH, 4, return-address stack entries (1..16)

Ports:
clk  in  1  system clock (divided clock in top level)
rst  in  1  asynchronous, active-high reset
INT  in  1  raw external interrupt request, asynchronous to clk
updPC  in  1  instruction-boundary strobe from control unit; PC changes only when high
isBranch  in  1  take brTarget instead of NPC
brTarget  in  AW  branch/jump target (ALU result)
iret  in  1  current instruction is return-from-interrupt
PC  out  AW  current program counter (registered)
NPC  out  AW  PC + PC_STEP (combinational, wraps modulo 2^AW)
int_ack  out  1  one-cycle pulse when an interrupt is taken
in_isr  out  1  high while stack depth > 0
depth  out  5  current stack occupancy
stk_err  out  1  sticky flag, set on iret with empty stack

Behaviour:
- Reset (async, immediate): PC=RESET_PC, stack depth=0, pending=0, both sync flops=0, int_ack=0, stk_err=0. Stack contents are don't-care.
- INT passes through a 2-FF synchroniser. A rising edge of the synchronised signal sets `pending`. An edge on the pin sets pending at the 3rd clk edge.
- Further edges while pending is set are absorbed: one service per pending. Level-high INT without a new edge does not re-trigger.
- seq_next = isBranch ? brTarget : NPC.
- When updPC=0: PC, stack and pending hold, except that pending can still be set. int_ack=0.
- When updPC=1, cases are evaluated in priority order:
  1. iret=1, depth>0 → PC ← stack[top], depth−1. Pending is not serviced this cycle.
  2. iret=1, depth=0 → stk_err ← 1, PC ← seq_next.
  3. pending=1 and depth<STACK_DEPTH → push seq_next, depth+1, PC ← INT_VEC, pending ← 0, int_ack=1 for this single cycle.
  4. pending=1 and depth=STACK_DEPTH → interrupt stays pending, PC ← seq_next. It is taken at the first updPC after a pop.
  5. Otherwise → PC ← seq_next.
- Edge coincident with service: if a new rising edge arrives in the same cycle pending is cleared, pending stays set (set wins).
- Stack is LIFO. The push address is the instruction that would have executed next, so a branch being taken at the boundary is preserved.
- PC arithmetic wraps modulo 2^AW with no overflow flag.
- stk_err clears only on rst.
- Reset mid-ISR discards all stacked return addresses.

Optional Feature:
PC_INT_TAILCHAIN_EN
- Defined: when updPC=1, iret=1, pending=1 and depth>0, there is no pop and no push. PC ← INT_VEC, pending ← 0, int_ack=1, depth unchanged. The pending ISR runs directly and returns to the original stacked address.
- Undefined: the priority rules above apply unchanged (pop first; the interrupt is taken at the next boundary).

Test Plan:
- Sequential and branch: reset, then updPC=1 for 3 cycles → PC 0,1,2,3. Then isBranch=1, brTarget=0x20 → PC=0x20. With updPC=0, PC holds.
- Interrupt entry: at PC=5, pulse INT. Pending is set at the 3rd edge; next updPC → PC=0x40, int_ack for 1 cycle, depth=1. iret at the next boundary → PC=6, depth=0, in_isr=0.
- Branch at the boundary: pending set and isBranch=1 with target 0x30 at the same updPC → PC=0x40. Subsequent iret → PC=0x30.
- Nesting and full stack: with STACK_DEPTH=2, take 2 nested interrupts → depth=2. A 3rd INT edge stays pending with PC sequential. After one iret (depth=1), the next boundary vectors to 0x40 with depth=2.
- Underflow and reset: iret at depth=0 → stk_err=1, PC=NPC, and stk_err persists. Assert rst mid-ISR at depth=2 → PC=0, depth=0 and stk_err=0 immediately, without waiting for a clock edge.
- Tail-chain (macro defined): depth=1, pending=1 and iret at the same boundary → PC=0x40, depth=1, int_ack=1. The following iret returns to the original address. With the macro undefined, the same stimulus gives PC=return address, and the interrupt is taken at the next boundary.

Source files
------------

// File: rtl/pc_int_ctrl.sv
`default_nettype none
//==============================================================================================
// pc_int_ctrl - PC register with synchronised interrupt entry and a nested return-address stack.
// Option macro PC_INT_TAILCHAIN_EN: iret with an interrupt pending re-enters the ISR directly. Rev 1.0
//==============================================================================================
module pc_int_ctrl #(
   parameter int unsigned   AW          = 32,
   parameter logic [AW-1:0] PC_STEP     = AW'(1),
   parameter logic [AW-1:0] RESET_PC    = '0,
   parameter logic [AW-1:0] INT_VEC     = AW'('h40),
   parameter int unsigned   STACK_DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          INT,
   input  logic          updPC,
   input  logic          isBranch,
   input  logic [AW-1:0] brTarget,
   input  logic          iret,
   output logic [AW-1:0] PC,
   output logic [AW-1:0] NPC,
   output logic          int_ack,
   output logic          in_isr,
   output logic [4:0]    depth,
   output logic          stk_err
);
   localparam int unsigned IW        = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam logic [4:0]  DEPTH_MAX = 5'(STACK_DEPTH);

   logic [AW-1:0] pc_q, pc_d;
   logic [4:0]    depth_q, depth_d;
   logic          pending_q, pending_d;
   logic          int_ack_q, int_ack_d;
   logic          stk_err_q, stk_err_d;
   logic          sync1_q, sync2_q, sync_dly_q;
   logic [AW-1:0] stack_q [2**IW];

   logic [AW-1:0] seq_next;
   logic          int_rise;
   logic          take;
   logic          push_en;
   logic [IW-1:0] top_idx;
   logic [IW-1:0] push_idx;

   assign NPC      = pc_q + PC_STEP;
   assign seq_next = isBranch ? brTarget : NPC;
   assign int_rise = sync2_q & ~sync_dly_q;
   assign top_idx  = IW'(depth_q - 5'd1);
   assign push_idx = IW'(depth_q);

   always_comb begin
      pc_d      = pc_q;
      depth_d   = depth_q;
      stk_err_d = stk_err_q;
      take      = 1'b0;
      push_en   = 1'b0;
      if (updPC) begin
         if (iret && (depth_q != 5'd0)) begin
`ifdef PC_INT_TAILCHAIN_EN
            // Pending ISR runs in place of the return; the stacked address stays for its iret.
            if (pending_q) begin
               pc_d = INT_VEC;
               take = 1'b1;
            end else begin
               pc_d    = stack_q[top_idx];
               depth_d = depth_q - 5'd1;
            end
`else
            pc_d    = stack_q[top_idx];
            depth_d = depth_q - 5'd1;
`endif
         end else if (iret) begin
            stk_err_d = 1'b1;
            pc_d      = seq_next;
         end else if (pending_q && (depth_q < DEPTH_MAX)) begin
            push_en = 1'b1;
            depth_d = depth_q + 5'd1;
            pc_d    = INT_VEC;
            take    = 1'b1;
         end else begin
            pc_d = seq_next;
         end
      end
      int_ack_d = take;
      // A fresh edge in the servicing cycle must not be lost: set wins over clear.
      pending_d = (pending_q & ~take) | int_rise;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q       <= RESET_PC;
         depth_q    <= '0;
         pending_q  <= 1'b0;
         int_ack_q  <= 1'b0;
         stk_err_q  <= 1'b0;
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         sync_dly_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         depth_q    <= depth_d;
         pending_q  <= pending_d;
         int_ack_q  <= int_ack_d;
         stk_err_q  <= stk_err_d;
         sync1_q    <= INT;
         sync2_q    <= sync1_q;
         sync_dly_q <= sync2_q;
      end
   end

   always_ff @(posedge clk) begin
      if (push_en) begin
         stack_q[push_idx] <= seq_next;
      end
   end

   assign PC      = pc_q;
   assign int_ack = int_ack_q;
   assign in_isr  = (depth_q != 5'd0);
   assign depth   = depth_q;
   assign stk_err = stk_err_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_int_ctrl.sv
`default_nettype none
// tb_pc_int_ctrl - directed scenarios plus randomized traffic against a queue-based reference model.
module tb_pc_int_ctrl;
   localparam int          SD  = 2;
   localparam logic [31:0] VEC = 32'h40;

   logic        clk = 1'b0, rst = 1'b1, INT = 1'b0, updPC = 1'b0, isBranch = 1'b0, iret = 1'b0;
   logic [31:0] brTarget = '0;
   logic [31:0] PC, NPC;
   logic        int_ack, in_isr, stk_err;
   logic [4:0]  depth;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] m_pc = '0;
   logic [31:0] m_stk[$];
   bit          m_hist[$];
   bit          m_pend = 0, m_err = 0, m_ack = 0;

   pc_int_ctrl #(.STACK_DEPTH(SD)) dut (
      .clk(clk), .rst(rst), .INT(INT), .updPC(updPC), .isBranch(isBranch),
      .brTarget(brTarget), .iret(iret), .PC(PC), .NPC(NPC), .int_ack(int_ack),
      .in_isr(in_isr), .depth(depth), .stk_err(stk_err)
   );

   always #5 clk = ~clk;

   // Pin rise seen at edge E-2 (low at E-3) becomes pending at edge E.
   task automatic model_edge();
      logic [31:0] seq;
      bit rise, take;
      int n;
      m_hist.push_back(INT);
      n    = m_hist.size();
      rise = (n >= 3) && m_hist[n-3] && !((n >= 4) && m_hist[n-4]);
      take = 0;
      seq  = isBranch ? brTarget : m_pc + 32'd1;
      if (updPC) begin
         if (iret && m_stk.size() > 0) begin
`ifdef PC_INT_TAILCHAIN_EN
            if (m_pend) begin m_pc = VEC; take = 1; end
            else m_pc = m_stk.pop_back();
`else
            m_pc = m_stk.pop_back();
`endif
         end else if (iret) begin
            m_err = 1; m_pc = seq;
         end else if (m_pend && m_stk.size() < SD) begin
            m_stk.push_back(seq); m_pc = VEC; take = 1;
         end else begin
            m_pc = seq;
         end
      end
      m_pend = (m_pend && !take) || rise;
      m_ack  = take;
   endtask

   task automatic model_reset();
      m_pc = '0; m_stk.delete(); m_hist.delete(); m_pend = 0; m_err = 0; m_ack = 0;
   endtask

   task automatic cycle(input bit u, input bit b, input logic [31:0] t, input bit ir, input bit iv);
      updPC = u; isBranch = b; brTarget = t; iret = ir; INT = iv;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic pulse_int();
      cycle(0, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);
   endtask

   task automatic release_reset();
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      n_tests++; if (PC !== 32'h0) begin n_fail++; $display("FAIL reset_pc got=%h exp=%h", PC, 32'h0); end
      n_tests++; if (NPC !== 32'h1) begin n_fail++; $display("FAIL reset_npc got=%h exp=%h", NPC, 32'h1); end
      n_tests++; if (depth !== 5'd0 || in_isr !== 1'b0) begin n_fail++; $display("FAIL reset_depth got=%0d/%b exp=0/0", depth, in_isr); end
      n_tests++; if (int_ack !== 1'b0 || stk_err !== 1'b0) begin n_fail++; $display("FAIL reset_flags got=%b%b exp=00", int_ack, stk_err); end
      model_reset();
      release_reset();
   endtask

   task automatic test_seq_branch();
      for (int i = 1; i <= 3; i++) begin
         cycle(1, 0, 0, 0, 0);
         n_tests++; if (PC !== 32'(i)) begin n_fail++; $display("FAIL seq_pc%0d got=%h exp=%h", i, PC, 32'(i)); end
      end
      cycle(1, 1, 32'h20, 0, 0);
      n_tests++; if (PC !== 32'h20) begin n_fail++; $display("FAIL branch_pc got=%h exp=%h", PC, 32'h20); end
      cycle(0, 1, 32'h55, 0, 0);
      cycle(0, 0, 0, 0, 0);
      n_tests++; if (PC !== 32'h20 || NPC !== 32'h21) begin n_fail++; $display("FAIL hold_pc got=%h/%h exp=20/21", PC, NPC); end
      cycle(1, 1, 32'hFFFF_FFFF, 0, 0);
      n_tests++; if (NPC !== 32'h0) begin n_fail++; $display("FAIL wrap_npc got=%h exp=%h", NPC, 32'h0); end
      cycle(1, 0, 0, 0, 0);
      n_tests++; if (PC !== 32'h0) begin n_fail++; $display("FAIL wrap_pc got=%h exp=%h", PC, 32'h0); end
   endtask

   task automatic test_int_entry();
      cycle(1, 1, 32'h5, 0, 0);
      pulse_int();
      n_tests++; if (PC !== 32'h5 || int_ack !== 1'b0) begin n_fail++; $display("FAIL int_wait got=%h/%b exp=5/0", PC, int_ack); end
      cycle(1, 0, 0, 0, 0);
      n_tests++; if (PC !== VEC || int_ack !== 1'b1) begin n_fail++; $display("FAIL int_vec got=%h/%b exp=40/1", PC, int_ack); end
      n_tests++; if (depth !== 5'd1 || in_isr !== 1'b1) begin n_fail++; $display("FAIL int_depth got=%0d/%b exp=1/1", depth, in_isr); end
      cycle(0, 0, 0, 0, 0);
      n_tests++; if (int_ack !== 1'b0 || PC !== VEC) begin n_fail++; $display("FAIL int_ack_pulse got=%b/%h exp=0/40", int_ack, PC); end
      cycle(1, 0, 0, 1, 0);
      n_tests++; if (PC !== 32'h6 || depth !== 5'd0 || in_isr !== 1'b0) begin n_fail++; $display("FAIL iret_ret got=%h/%0d/%b exp=6/0/0", PC, depth, in_isr); end
   endtask

   task automatic test_branch_boundary();
      pulse_int();
      cycle(1, 1, 32'h30, 0, 0);
      n_tests++; if (PC !== VEC || int_ack !== 1'b1) begin n_fail++; $display("FAIL brint_vec got=%h/%b exp=40/1", PC, int_ack); end
      cycle(1, 0, 0, 1, 0);
      n_tests++; if (PC !== 32'h30) begin n_fail++; $display("FAIL brint_ret got=%h exp=%h", PC, 32'h30); end
   endtask

   task automatic test_nesting();
      pulse_int(); cycle(1, 0, 0, 0, 0);
      pulse_int(); cycle(1, 0, 0, 0, 0);
      n_tests++; if (PC !== VEC || depth !== 5'd2) begin n_fail++; $display("FAIL nest2 got=%h/%0d exp=40/2", PC, depth); end
      pulse_int(); cycle(1, 0, 0, 0, 0);
      n_tests++; if (PC !== 32'h41 || depth !== 5'd2 || int_ack !== 1'b0) begin n_fail++; $display("FAIL full_seq got=%h/%0d/%b exp=41/2/0", PC, depth, int_ack); end
      cycle(1, 0, 0, 0, 0);
      n_tests++; if (PC !== 32'h42 || int_ack !== 1'b0) begin n_fail++; $display("FAIL full_hold got=%h/%b exp=42/0", PC, int_ack); end
      cycle(1, 0, 0, 1, 0);
      n_tests++; if (PC !== 32'h41 || depth !== 5'd1 || int_ack !== 1'b0) begin n_fail++; $display("FAIL full_pop got=%h/%0d/%b exp=41/1/0", PC, depth, int_ack); end
      cycle(1, 0, 0, 0, 0);
      n_tests++; if (PC !== VEC || depth !== 5'd2 || int_ack !== 1'b1) begin n_fail++; $display("FAIL full_take got=%h/%0d/%b exp=40/2/1", PC, depth, int_ack); end
      cycle(1, 0, 0, 1, 0);
      n_tests++; if (PC !== 32'h42 || depth !== 5'd1) begin n_fail++; $display("FAIL nest_ret1 got=%h/%0d exp=42/1", PC, depth); end
      cycle(1, 0, 0, 1, 0);
      n_tests++; if (PC !== 32'h31 || depth !== 5'd0) begin n_fail++; $display("FAIL nest_ret0 got=%h/%0d exp=31/0", PC, depth); end
   endtask

   task automatic test_absorb_level();
      int acks;
      cycle(0, 0, 0, 0, 1); cycle(0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 1); cycle(0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0); cycle(0, 0, 0, 0, 0);
      acks = 0;
      for (int i = 0; i < 4; i++) begin cycle(1, 0, 0, 0, 0); acks += int'(int_ack); end
      n_tests++; if (acks != 1) begin n_fail++; $display("FAIL absorb_acks got=%0d exp=1", acks); end
      cycle(1, 0, 0, 1, 0);
      acks = 0;
      for (int i = 0; i < 8; i++) begin cycle(1, 0, 0, 0, 1); acks += int'(int_ack); end
      n_tests++; if (acks != 1) begin n_fail++; $display("FAIL level_acks got=%0d exp=1", acks); end
      cycle(1, 0, 0, 1, 1);
      acks = 0;
      for (int i = 0; i < 4; i++) begin cycle(1, 0, 0, 0, 1); acks += int'(int_ack); end
      n_tests++; if (acks != 0 || depth !== 5'd0) begin n_fail++; $display("FAIL level_noretrig got=%0d/%0d exp=0/0", acks, depth); end
      cycle(0, 0, 0, 0, 0);
   endtask

   task automatic test_underflow_reset();
      logic [31:0] p;
      p = PC;
      cycle(1, 0, 0, 1, 0);
      n_tests++; if (stk_err !== 1'b1 || PC !== p + 32'd1) begin n_fail++; $display("FAIL underflow got=%b/%h exp=1/%h", stk_err, PC, p + 32'd1); end
      cycle(1, 0, 0, 0, 0); cycle(0, 0, 0, 0, 0);
      n_tests++; if (stk_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky got=%b exp=1", stk_err); end
      pulse_int(); cycle(1, 0, 0, 0, 0);
      pulse_int(); cycle(1, 0, 0, 0, 0);
      n_tests++; if (depth !== 5'd2) begin n_fail++; $display("FAIL pre_rst_depth got=%0d exp=2", depth); end
      #2 rst = 1'b1;
      #1;
      n_tests++; if (PC !== 32'h0 || depth !== 5'd0 || stk_err !== 1'b0 || in_isr !== 1'b0) begin n_fail++; $display("FAIL async_rst got=%h/%0d/%b/%b exp=0/0/0/0", PC, depth, stk_err, in_isr); end
      model_reset();
      release_reset();
   endtask

   task automatic test_tailchain();
      cycle(1, 1, 32'h10, 0, 0);
      pulse_int(); cycle(1, 0, 0, 0, 0);
      pulse_int(); cycle(1, 0, 0, 1, 0);
`ifdef PC_INT_TAILCHAIN_EN
      n_tests++; if (PC !== VEC || depth !== 5'd1 || int_ack !== 1'b1) begin n_fail++; $display("FAIL tail_chain got=%h/%0d/%b exp=40/1/1", PC, depth, int_ack); end
      cycle(1, 0, 0, 1, 0);
      n_tests++; if (PC !== 32'h11 || depth !== 5'd0) begin n_fail++; $display("FAIL tail_ret got=%h/%0d exp=11/0", PC, depth); end
`else
      n_tests++; if (PC !== 32'h11 || depth !== 5'd0 || int_ack !== 1'b0) begin n_fail++; $display("FAIL tail_pop got=%h/%0d/%b exp=11/0/0", PC, depth, int_ack); end
      cycle(1, 0, 0, 0, 0);
      n_tests++; if (PC !== VEC || depth !== 5'd1 || int_ack !== 1'b1) begin n_fail++; $display("FAIL tail_next got=%h/%0d/%b exp=40/1/1", PC, depth, int_ack); end
      cycle(1, 0, 0, 1, 0);
      n_tests++; if (PC !== 32'h12 || depth !== 5'd0) begin n_fail++; $display("FAIL tail_ret got=%h/%0d exp=12/0", PC, depth); end
`endif
   endtask

   task automatic test_random();
      bit lvl;
      lvl = 0;
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 4) == 0) lvl = !lvl;
         cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 5) == 0, lvl);
         n_tests++; if (PC !== m_pc) begin n_fail++; $display("FAIL rand_pc c=%0d got=%h exp=%h", c, PC, m_pc); end
         n_tests++; if (NPC !== m_pc + 32'd1) begin n_fail++; $display("FAIL rand_npc c=%0d got=%h exp=%h", c, NPC, m_pc + 32'd1); end
         n_tests++; if (depth !== 5'(m_stk.size()) || in_isr !== (m_stk.size() > 0)) begin n_fail++; $display("FAIL rand_depth c=%0d got=%0d exp=%0d", c, depth, m_stk.size()); end
         n_tests++; if (int_ack !== m_ack) begin n_fail++; $display("FAIL rand_ack c=%0d got=%b exp=%b", c, int_ack, m_ack); end
         n_tests++; if (stk_err !== m_err) begin n_fail++; $display("FAIL rand_err c=%0d got=%b exp=%b", c, stk_err, m_err); end
      end
   endtask

   initial begin
      test_reset();
      test_seq_branch();
      test_int_entry();
      test_branch_boundary();
      test_nesting();
      test_absorb_level();
      test_underflow_reset();
      test_tailchain();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
